// File: rtl/issue_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// issue_dispatch_scheduler
//
// Steers up to DISPATCH_WIDTH renamed micro-ops per cycle into BANK_NUM issue
// banks of a single issue queue. Each valid lane goes to a distinct, eligible
// bank, picked in order of increasing estimated occupancy. The chosen writes
// are registered once before they reach the bank write ports.
//
// Occupancy estimate per bank = reported count + staged write. The staged
// write is not yet visible in bank_num, so adding it keeps the estimate from
// under-counting. Dequeues are ignored, which makes the estimate conservative.
//
// Optional build macro ISSUE_SCHED_PERF_RR_EN:
//   - breaks occupancy ties round-robin from rr_ptr instead of lowest index
//   - adds the stall_cnt output (saturating dispatch-blocked cycle count)
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-low reset
//   dis_valid  per-lane op valid
//   dis_data   per-lane payload, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dis_ready  all valid lanes are accepted this cycle
//   bank_num   per-bank occupied-entry count (CNT_WIDTH bits per bank)
//   bank_full  per-bank full flag
//   redirect   backend redirect; flushes dispatch and the staging register
//   bank_en    per-bank write enable (registered, masked by redirect)
//   bank_data  per-bank write payload (registered)
//   stall_cnt  dispatch-blocked cycle counter (optional build only)
// ---------------------------------------------------------------------------
module issue_dispatch_scheduler #(
  parameter int BANK_NUM       = 4,
  parameter int DEPTH          = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int DISPATCH_WIDTH = 2,
  parameter int CNT_WIDTH      = $clog2(DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DISPATCH_WIDTH-1:0]          dis_valid,
  input  logic [DISPATCH_WIDTH*DATA_WIDTH-1:0] dis_data,
  output logic                               dis_ready,
  input  logic [BANK_NUM*CNT_WIDTH-1:0]      bank_num,
  input  logic [BANK_NUM-1:0]                bank_full,
  input  logic                               redirect,
  output logic [BANK_NUM-1:0]                bank_en,
  output logic [BANK_NUM*DATA_WIDTH-1:0]     bank_data
`ifdef ISSUE_SCHED_PERF_RR_EN
  ,
  output logic [31:0]                        stall_cnt
`endif
);

  // RW holds counts 0..BANK_NUM; PW holds a bank index.
  localparam int unsigned RW = $clog2(BANK_NUM) + 1;
  localparam int unsigned PW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  logic [BANK_NUM-1:0]            bank_en_q;
  logic [BANK_NUM*DATA_WIDTH-1:0] bank_data_q;

  logic [CNT_WIDTH:0]    occ      [BANK_NUM];
  logic [BANK_NUM-1:0]   elig;
  logic [RW-1:0]         n_elig;
  logic [PW-1:0]         tie_key  [BANK_NUM];
  logic [RW-1:0]         rank     [BANK_NUM];
  logic [RW-1:0]         slot     [DISPATCH_WIDTH];
  logic [RW-1:0]         lane_cnt;
  logic                  accept;
  logic [BANK_NUM-1:0]   alloc;
  logic [DATA_WIDTH-1:0] alloc_data [BANK_NUM];

`ifdef ISSUE_SCHED_PERF_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] last_bank;
`endif

  // Occupancy estimate and eligibility, one extra bit so the sum never wraps.
  always_comb begin
    n_elig = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      occ[b]  = {1'b0, bank_num[b*CNT_WIDTH +: CNT_WIDTH]}
              + {{CNT_WIDTH{1'b0}}, bank_en_q[b]};
      elig[b] = (occ[b] < (CNT_WIDTH+1)'(DEPTH)) && !bank_full[b];
      n_elig  = n_elig + {{(RW-1){1'b0}}, elig[b]};
    end
  end

  // Tie-break order: smaller key wins among banks with equal occupancy.
  always_comb begin
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
`ifdef ISSUE_SCHED_PERF_RR_EN
      // Distance from rr_ptr modulo BANK_NUM; truncation to PW bits is
      // harmless because the true distance is always below BANK_NUM.
      tie_key[b] = (PW'(b) >= rr_ptr) ? (PW'(b) - rr_ptr)
                                      : (PW'(b + BANK_NUM) - rr_ptr);
`else
      tie_key[b] = PW'(b);
`endif
    end
  end

  // rank[b] = number of eligible banks ordered ahead of b. Ranks of the
  // eligible banks are unique, so rank k identifies the k-th best bank.
  always_comb begin
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      rank[b] = '0;
      for (int unsigned c = 0; c < BANK_NUM; c++) begin
        if (elig[c] && ((occ[c] < occ[b]) ||
                        ((occ[c] == occ[b]) && (tie_key[c] < tie_key[b])))) begin
          rank[b] = rank[b] + RW'(1);
        end
      end
    end
  end

  // slot[i] = number of valid lanes below lane i.
  always_comb begin
    lane_cnt = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      slot[i]  = lane_cnt;
      lane_cnt = lane_cnt + {{(RW-1){1'b0}}, dis_valid[i]};
    end
  end

  // Readiness only depends on having enough eligible banks for a full group,
  // never on how many lanes are actually valid.
  assign dis_ready = rst && !redirect && (n_elig >= RW'(DISPATCH_WIDTH));
  assign accept    = dis_ready && (|dis_valid);

  // Lane-to-bank allocation: the k-th valid lane takes the rank-k bank.
  always_comb begin
    alloc = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      alloc_data[b] = '0;
    end
`ifdef ISSUE_SCHED_PERF_RR_EN
    last_bank = '0;
`endif
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        if (accept && dis_valid[i] && elig[b] && (rank[b] == slot[i])) begin
          alloc[b]      = 1'b1;
          alloc_data[b] = dis_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ISSUE_SCHED_PERF_RR_EN
          // Lanes are scanned in ascending order, so this ends on the bank
          // of the highest valid lane.
          last_bank = PW'(b);
`endif
        end
      end
    end
  end

  // Staging register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_en_q   <= '0;
      bank_data_q <= '0;
    end else begin
      bank_en_q <= alloc & {BANK_NUM{!redirect}};
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        if (alloc[b]) begin
          bank_data_q[b*DATA_WIDTH +: DATA_WIDTH] <= alloc_data[b];
        end
      end
    end
  end

  // A redirect squashes the staged writes before they reach the banks.
  assign bank_en   = bank_en_q & {BANK_NUM{!redirect}};
  assign bank_data = bank_data_q;

`ifdef ISSUE_SCHED_PERF_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (last_bank == PW'(BANK_NUM - 1)) ? '0 : (last_bank + PW'(1));
      end
      if ((|dis_valid) && !dis_ready && !redirect && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_issue_dispatch_scheduler
//
// Directed bench for issue_dispatch_scheduler with default parameters
// (4 banks, depth 8, 64-bit payload, 2 lanes). Expected values are worked
// out by hand for both the default build and ISSUE_SCHED_PERF_RR_EN.
// ---------------------------------------------------------------------------
module tb_issue_dispatch_scheduler;

  localparam int BANK_NUM = 4;
  localparam int DEPTH = 8;
  localparam int DATA_WIDTH = 64;
  localparam int DISPATCH_WIDTH = 2;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                                 clk;
  logic                                 rst;
  logic [DISPATCH_WIDTH-1:0]            dis_valid;
  logic [DISPATCH_WIDTH*DATA_WIDTH-1:0] dis_data;
  logic                                 dis_ready;
  logic [BANK_NUM*CNT_WIDTH-1:0]        bank_num;
  logic [BANK_NUM-1:0]                  bank_full;
  logic                                 redirect;
  logic [BANK_NUM-1:0]                  bank_en;
  logic [BANK_NUM*DATA_WIDTH-1:0]       bank_data;
`ifdef ISSUE_SCHED_PERF_RR_EN
  logic [31:0]                          stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  issue_dispatch_scheduler #(
    .BANK_NUM      (BANK_NUM),
    .DEPTH         (DEPTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DISPATCH_WIDTH(DISPATCH_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dis_valid(dis_valid),
    .dis_data (dis_data),
    .dis_ready(dis_ready),
    .bank_num (bank_num),
    .bank_full(bank_full),
    .redirect (redirect),
    .bank_en  (bank_en),
    .bank_data(bank_data)
`ifdef ISSUE_SCHED_PERF_RR_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bd(input int unsigned b);
    return bank_data[b*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  localparam logic [63:0] A = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] D = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_0005;
  localparam logic [63:0] F = 64'hFFFF_0000_0000_0006;
  localparam logic [63:0] G = 64'h1111_0000_0000_0007;
  localparam logic [63:0] H = 64'h2222_0000_0000_0008;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp_en;
    logic [63:0] l0;
    logic [63:0] l1;
    int unsigned l0_bank;

    rst       = 1'b1;
    dis_valid = '0;
    dis_data  = '0;
    bank_num  = '0;
    bank_full = '0;
    redirect  = 1'b0;
    #1 rst = 1'b0;
    #1;
    // Reset state
    chk("reset_bank_en", 64'(bank_en), 64'h0);
    chk("reset_bank_data_zero", 64'(bank_data == '0), 64'h1);
    chk("reset_dis_ready", 64'(dis_ready), 64'h0);
`ifdef ISSUE_SCHED_PERF_RR_EN
    chk("reset_stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    tick();
    tick();
    rst = 1'b1;

    // Test 1: empty banks, two ops go to banks 0 and 1
    dis_valid = 2'b11;
    dis_data  = {B, A};
    #1 chk("t1_ready", 64'(dis_ready), 64'h1);
    tick();
    chk("t1_bank_en", 64'(bank_en), 64'h3);
    chk("t1_data0", bd(0), A);
    chk("t1_data1", bd(1), B);

    // Idle cycle: ready with no valid lanes, nothing staged
    dis_valid = 2'b00;
    #1 chk("idle_ready", 64'(dis_ready), 64'h1);
    tick();
    chk("idle_bank_en", 64'(bank_en), 64'h0);
    chk("idle_data0_held", bd(0), A);

    // Test 2: occ bank0..3 = 3,1,2,1
    bank_num  = {4'd1, 4'd2, 4'd1, 4'd3};
    dis_valid = 2'b11;
    dis_data  = {D, C};
    #1 chk("t2_ready", 64'(dis_ready), 64'h1);
    tick();
    chk("t2_bank_en", 64'(bank_en), 64'hA);
`ifdef ISSUE_SCHED_PERF_RR_EN
    // rr_ptr = 2 after test 1: bank3 is ahead of bank1
    chk("t2_data3", bd(3), C);
    chk("t2_data1", bd(1), D);
`else
    chk("t2_data1", bd(1), C);
    chk("t2_data3", bd(3), D);
`endif
    chk("t2_data2_untouched", bd(2), 64'h0);

    // Stage a single write into bank 2 (occ 5,6,0,6)
    bank_num  = {4'd5, 4'd0, 4'd5, 4'd5};
    dis_valid = 2'b01;
    dis_data  = {64'h0, E};
    #1 chk("t3pre_ready", 64'(dis_ready), 64'h1);
    tick();
    chk("t3pre_bank_en", 64'(bank_en), 64'h4);
    chk("t3pre_data2", bd(2), E);

    // Test 3: bank_num 8,8,7,5 with bank2 staged -> only bank3 eligible
    bank_num  = {4'd5, 4'd7, 4'd8, 4'd8};
    dis_data  = {64'h0, F};
    #1 chk("t3_ready", 64'(dis_ready), 64'h0);
    tick();
    chk("t3_bank_en", 64'(bank_en), 64'h0);
`ifdef ISSUE_SCHED_PERF_RR_EN
    chk("t3_data3_held", bd(3), C);
    chk("t3_stall_cnt", 64'(stall_cnt), 64'h1);
`else
    chk("t3_data3_held", bd(3), D);
`endif

    // Test 4: accept two, then redirect
    bank_num  = '0;
    dis_valid = 2'b11;
    dis_data  = {H, G};
    #1 chk("t4_ready", 64'(dis_ready), 64'h1);
    tick();
`ifdef ISSUE_SCHED_PERF_RR_EN
    chk("t4_bank_en_staged", 64'(bank_en), 64'h9);
`else
    chk("t4_bank_en_staged", 64'(bank_en), 64'h3);
`endif
    redirect = 1'b1;
    #1;
    chk("t4_redirect_bank_en", 64'(bank_en), 64'h0);
    chk("t4_redirect_ready", 64'(dis_ready), 64'h0);
    tick();
    redirect  = 1'b0;
    dis_valid = 2'b00;
    chk("t4_after_bank_en", 64'(bank_en), 64'h0);
`ifdef ISSUE_SCHED_PERF_RR_EN
    chk("t4_stall_cnt", 64'(stall_cnt), 64'h1);
`endif

    // Test 5: sustained dispatch with bank_num held at 0
    dis_valid = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      l0 = 64'h100 + 64'(k);
      l1 = 64'h200 + 64'(k);
      dis_data = {l1, l0};
`ifdef ISSUE_SCHED_PERF_RR_EN
      exp_en  = (k % 2 == 1) ? 4'b0110 : 4'b1001;
      l0_bank = (k % 2 == 1) ? 1 : 3;
`else
      exp_en  = (k % 2 == 1) ? 4'b0011 : 4'b1100;
      l0_bank = (k % 2 == 1) ? 0 : 2;
`endif
      #1 chk("t5_ready", 64'(dis_ready), 64'h1);
      tick();
      chk("t5_bank_en", 64'(bank_en), 64'(exp_en));
      chk("t5_lane0_data", bd(l0_bank), l0);
    end

    // Test 6: asynchronous reset between clock edges
    #2 rst = 1'b0;
    #1;
    chk("t6_bank_en", 64'(bank_en), 64'h0);
    chk("t6_bank_data_zero", 64'(bank_data == '0), 64'h1);
    chk("t6_ready", 64'(dis_ready), 64'h0);
    tick();
    chk("t6_ready_held", 64'(dis_ready), 64'h0);
    rst = 1'b1;

    // Full flags: only bank3 eligible blocks even a single valid lane
    dis_valid = 2'b01;
    dis_data  = {64'h0, 64'h5A5A};
    bank_full = 4'b0111;
    #1 chk("full_ready", 64'(dis_ready), 64'h0);
    tick();
    chk("full_bank_en", 64'(bank_en), 64'h0);
`ifdef ISSUE_SCHED_PERF_RR_EN
    chk("full_stall_cnt", 64'(stall_cnt), 64'h1);
`endif
    bank_full = 4'b0011;
    #1 chk("half_full_ready", 64'(dis_ready), 64'h1);
    tick();
    chk("half_full_bank_en", 64'(bank_en), 64'h4);
    chk("half_full_data2", bd(2), 64'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
